// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART tx byte channel.
// A grant is held until the owner's last byte is accepted or it idles out.
module uart_tx_arbiter #(
    parameter int PORTS   = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PORTS-1:0]   req_valid,
    input  logic [PORTS-1:0]   req_last,
    input  logic [8*PORTS-1:0] req_byte,
    output logic [PORTS-1:0]   req_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_byte,
    input  logic               tx_ready,
    output logic [PORTS-1:0]   grant,
    output logic               evicted
);
    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   nxt;
    logic [IW-1:0]   j;
    logic [PORTS-1:0] pick_oh;
    logic            found;
    logic            xfer;

    // First requester at or after the round-robin pointer
    always_comb begin
        pick    = '0;
        found   = 1'b0;
        j       = '0;
        pick_oh = '0;
        for (int k = 0; k < PORTS; k++) begin
            j = IW'((int'(ptr) + k) % PORTS);
            if (!found && req_valid[j]) begin
                found = 1'b1;
                pick  = j;
            end
        end
        pick_oh[pick] = 1'b1;
    end

    always_comb begin
        nxt = idx + 1'b1;
        if (PORTS == 1 || int'(idx) == PORTS - 1)
            nxt = '0;
    end

    // Owner path is combinational so the first byte moves in the grant cycle
    always_comb begin
        tx_valid  = 1'b0;
        tx_byte   = 8'h00;
        req_ready = '0;
        if (state == LOCKED) begin
            tx_valid  = req_valid[idx];
            tx_byte   = req_byte[{idx, 3'b000} +: 8];
            req_ready = tx_ready ? grant : '0;
        end
    end

    assign xfer    = tx_valid & tx_ready;
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            idx     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            evicted <= 1'b0;
        end else begin
            evicted <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= LOCKED;
                        grant <= pick_oh;
                        idx   <= pick;
                        cnt   <= '0;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        cnt <= '0;
                        if (req_last[idx]) begin
                            state <= IDLE;
                            grant <= '0;
                            ptr   <= nxt;
                        end
                    end else if (!req_valid[idx]) begin
                        // UART stalls never reach here, so they never count
                        if (TIMEOUT != 0 && cnt_inc == CW'(TIMEOUT)) begin
                            state   <= IDLE;
                            grant   <= '0;
                            ptr     <= nxt;
                            cnt     <= '0;
                            evicted <= 1'b1;
                        end else if (cnt != '1) begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two requesters, TIMEOUT=16.
// Drivers feed per-port byte queues; a monitor checks each tx transfer.
module tb_uart_tx_arbiter;
    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_last;
    logic [15:0] req_byte;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic [1:0]  grant;
    logic        evicted;

    uart_tx_arbiter #(.PORTS(2), .TIMEOUT(16)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_byte(req_byte),
        .req_ready(req_ready),
        .tx_valid(tx_valid),
        .tx_byte(tx_byte),
        .tx_ready(tx_ready),
        .grant(grant),
        .evicted(evicted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] pq0[$];
    logic [8:0] pq1[$];
    logic [8:0] exp_q[$];
    logic [1:0] fired;
    logic       ev_seen;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive();
        req_valid[0] = (pq0.size() > 0);
        req_valid[1] = (pq1.size() > 0);
        {req_last[0], req_byte[7:0]}  = (pq0.size() > 0) ? pq0[0] : 9'h0;
        {req_last[1], req_byte[15:8]} = (pq1.size() > 0) ? pq1[0] : 9'h0;
    endtask

    task automatic push(input int p, input logic [7:0] b, input logic l);
        if (p == 0) pq0.push_back({l, b});
        else        pq1.push_back({l, b});
    endtask

    task automatic expect_tx(input logic p, input logic [7:0] b);
        exp_q.push_back({p, b});
    endtask

    // One clock: sample handshakes, pop accepted bytes, re-present heads
    task automatic tick();
        @(negedge clk);
        fired = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (fired[0]) void'(pq0.pop_front());
        if (fired[1]) void'(pq1.pop_front());
        drive();
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || exp_q.size() > 0 ||
                grant != 2'b00) && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(n < 200), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pq0.delete();
        pq1.delete();
        exp_q.delete();
        drive();
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset && tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got byte %0h grant %b expected none",
                         tx_byte, grant);
            end else begin
                e = exp_q.pop_front();
                if (tx_byte !== e[7:0] || grant !== (2'b01 << e[8])) begin
                    errors++;
                    $display("FAIL tx_byte: got %0h grant %b expected %0h port %0d",
                             tx_byte, grant, e[7:0], e[8]);
                end
            end
        end
    end

    logic [1:0] g2 [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b00,
                           2'b01, 2'b00, 2'b10, 2'b00};

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_byte  = '0;
        tx_ready  = 1'b1;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_evicted", 32'(evicted), 32'd0);
        do_reset();

        // single 3-byte packet from port 0
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
        expect_tx(0, 8'h41); expect_tx(0, 8'h42); expect_tx(0, 8'h43);
        drive();
        tick();
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_first", 32'(tx_byte), 32'h41);
        tick();
        chk("t1_second", 32'(tx_byte), 32'h42);
        tick();
        chk("t1_third", 32'(tx_byte), 32'h43);
        tick();
        chk("t1_release", 32'(grant), 32'd0);
        drain("t1_drain");

        // both ports contend: strict alternation with one idle cycle
        do_reset();
        push(0, 8'hA0, 0); push(0, 8'hA1, 1); push(0, 8'hC0, 1);
        push(1, 8'hB0, 1); push(1, 8'hD0, 1);
        expect_tx(0, 8'hA0); expect_tx(0, 8'hA1); expect_tx(1, 8'hB0);
        expect_tx(0, 8'hC0); expect_tx(1, 8'hD0);
        drive();
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("t2_grant%0d", i), 32'(grant), 32'(g2[i]));
        end
        drain("t2_drain");

        // port 0 must wait while port 1 owns the channel
        do_reset();
        push(1, 8'hE0, 0); push(1, 8'hE1, 0); push(1, 8'hE2, 1);
        expect_tx(1, 8'hE0); expect_tx(1, 8'hE1); expect_tx(1, 8'hE2);
        expect_tx(0, 8'hF0);
        drive();
        tick();
        push(0, 8'hF0, 1);
        drive();
        #1;
        chk("t3_ready0_a", 32'(req_ready[0]), 32'd0);
        chk("t3_grant_a", 32'(grant), 32'd2);
        tick();
        chk("t3_ready0_b", 32'(req_ready[0]), 32'd0);
        tick();
        chk("t3_ready0_c", 32'(req_ready[0]), 32'd0);
        drain("t3_drain");

        // owner goes quiet after one byte and is evicted
        do_reset();
        push(0, 8'h47, 0);
        push(1, 8'h48, 1);
        expect_tx(0, 8'h47); expect_tx(1, 8'h48);
        drive();
        ev_seen = 1'b0;
        repeat (17) begin
            tick();
            ev_seen |= evicted;
        end
        chk("t4_no_early_evict", 32'(ev_seen), 32'd0);
        chk("t4_still_owner", 32'(grant), 32'd1);
        tick();
        chk("t4_evicted", 32'(evicted), 32'd1);
        chk("t4_grant_drop", 32'(grant), 32'd0);
        tick();
        chk("t4_evict_pulse", 32'(evicted), 32'd0);
        chk("t4_next_owner", 32'(grant), 32'd2);
        drain("t4_drain");

        // long UART stall never evicts
        do_reset();
        tx_ready = 1'b0;
        push(0, 8'h4A, 1);
        expect_tx(0, 8'h4A);
        drive();
        ev_seen = 1'b0;
        repeat (100) begin
            tick();
            ev_seen |= evicted;
        end
        chk("t5_no_evict", 32'(ev_seen), 32'd0);
        chk("t5_owner", 32'(grant), 32'd1);
        chk("t5_tx_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        tick();
        chk("t5_accepted", 32'(grant), 32'd0);
        drain("t5_drain");

        // asynchronous reset mid-packet, pointer returns to port 0
        push(0, 8'h50, 1);
        expect_tx(0, 8'h50);
        drive();
        drain("t6_pre_drain");
        push(1, 8'h60, 0); push(1, 8'h61, 1);
        drive();
        tick();
        chk("t6_locked", 32'({grant, tx_valid}), 32'b101);
        reset = 1'b1;
        #1;
        chk("t6_tx_valid", 32'(tx_valid), 32'd0);
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        do_reset();
        push(1, 8'h71, 1);
        push(0, 8'h70, 1);
        expect_tx(0, 8'h70); expect_tx(1, 8'h71);
        drive();
        tick();
        chk("t6_port0_first", 32'(grant), 32'd1);
        drain("t6_drain");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
